// File: rtl/kgp_multicycle_ctrl_if.sv
// Control bundle between the KGP multi-cycle sequencer (master) and the IR / data path (slave).
// The cycle_count/instr_count members exist only when KGP_CTRL_PERF_EN is defined.
interface kgp_multicycle_ctrl_if #(
  parameter int OPC_W  = 6,
  parameter int FUNC_W = 6
);
  logic [OPC_W-1:0]  opcode;
  logic [FUNC_W-1:0] func;
  logic              dmem_ready;
  logic              halt;
  logic              ir_write;
  logic              pc_write;
  logic [1:0]        reg_write;
  logic              imm_mux_ctrl;
  logic              alu_mux_ctrl;
  logic [3:0]        alu_op;
  logic              dmem_enable;
  logic              dmem_write_enable;
  logic [1:0]        reg_write_mux_ctrl;
  logic [4:0]        br_op;
  logic              is_branch;
  logic              illegal;
  logic              mem_err;
  logic [2:0]        state_out;
`ifdef KGP_CTRL_PERF_EN
  logic [31:0]       cycle_count;
  logic [31:0]       instr_count;
`endif

  modport master (
    input  opcode, func, dmem_ready, halt,
    output ir_write, pc_write, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
           dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, is_branch,
           illegal, mem_err, state_out
`ifdef KGP_CTRL_PERF_EN
    , output cycle_count, instr_count
`endif
  );

  modport slave (
    output opcode, func, dmem_ready, halt,
    input  ir_write, pc_write, reg_write, imm_mux_ctrl, alu_mux_ctrl, alu_op,
           dmem_enable, dmem_write_enable, reg_write_mux_ctrl, br_op, is_branch,
           illegal, mem_err, state_out
`ifdef KGP_CTRL_PERF_EN
    , input cycle_count, instr_count
`endif
  );
endinterface

// File: rtl/kgp_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the KGP mini-RISC data path.
// Optional performance counters are compiled in with `define KGP_CTRL_PERF_EN.
module kgp_multicycle_ctrl #(
  parameter int OPC_W       = 6,
  parameter int FUNC_W      = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  kgp_multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_CALL, CLS_ILLEGAL
  } cls_e;

  state_e            state_q, state_d;
  logic [OPC_W-1:0]  opc_q, opc_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [TO_W-1:0]   cnt_q, cnt_d;
  cls_e              cls;
  logic              timeout;
  logic              unused_func;

  logic       ir_write, pc_write, imm_mux_ctrl, alu_mux_ctrl;
  logic       dmem_enable, dmem_write_enable, is_branch, illegal, mem_err;
  logic [1:0] reg_write, reg_write_mux_ctrl;
  logic [3:0] alu_op;
  logic [4:0] br_op;

  assign unused_func = ^func_q;
  assign timeout     = (MEM_TIMEOUT != 0) && (cnt_q == TO_W'(MEM_TIMEOUT));

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opc_q == OPC_W'(0))      cls = CLS_R;
    else if (opc_q == OPC_W'(1)) cls = CLS_I;
    else if (opc_q == OPC_W'(2)) cls = CLS_LOAD;
    else if (opc_q == OPC_W'(3)) cls = CLS_STORE;
    else if (opc_q == OPC_W'(4)) cls = (func_q[4:0] == 5'h02) ? CLS_CALL : CLS_BRANCH;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      opc_q   <= '0;
      func_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
    end
  end

  // opcode/func are captured on the FETCH->DECODE edge so every decoded output,
  // DECODE included, comes from registers rather than the live IR fields.
  always_comb begin
    state_d = state_q;
    opc_d   = opc_q;
    func_d  = func_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        if (!bus.halt) begin
          state_d = DECODE;
          opc_d   = bus.opcode;
          func_d  = bus.func;
        end
      end
      DECODE: state_d = EXEC;
      EXEC: begin
        case (cls)
          CLS_R, CLS_I, CLS_CALL: state_d = WB;
          CLS_LOAD, CLS_STORE:    state_d = MEM;
          default:                state_d = FETCH;
        endcase
      end
      MEM: begin
        if (bus.dmem_ready) begin
          cnt_d   = '0;
          state_d = (cls == CLS_LOAD) ? WB : FETCH;
        end else if (timeout) begin
          cnt_d   = '0;
          state_d = FETCH;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end
      WB:      state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ir_write           = 1'b0;
    pc_write           = 1'b0;
    reg_write          = 2'b00;
    imm_mux_ctrl       = 1'b0;
    alu_mux_ctrl       = 1'b0;
    alu_op             = 4'h0;
    dmem_enable        = 1'b0;
    dmem_write_enable  = 1'b0;
    reg_write_mux_ctrl = 2'b00;
    br_op              = 5'h00;
    is_branch          = 1'b0;
    illegal            = 1'b0;
    mem_err            = 1'b0;

    // Gating with rst keeps every output quiet while reset is held.
    if (state_q == FETCH) ir_write = rst && !bus.halt;

    if (state_q != FETCH) begin
      case (cls)
        CLS_R: begin
          alu_op             = func_q[3:0];
          reg_write_mux_ctrl = 2'b10;
        end
        CLS_I: begin
          alu_op             = func_q[3:0];
          alu_mux_ctrl       = 1'b1;
          reg_write_mux_ctrl = 2'b10;
        end
        CLS_LOAD, CLS_STORE: begin
          alu_mux_ctrl       = 1'b1;
          imm_mux_ctrl       = 1'b1;
          reg_write_mux_ctrl = 2'b01;
        end
        CLS_BRANCH, CLS_CALL: br_op = func_q[4:0];
        default: ;
      endcase
    end

    case (state_q)
      EXEC: begin
        if (cls == CLS_BRANCH || cls == CLS_CALL) begin
          pc_write  = 1'b1;
          is_branch = 1'b1;
        end else if (cls == CLS_ILLEGAL) begin
          pc_write = 1'b1;
          illegal  = 1'b1;
        end
      end
      MEM: begin
        dmem_enable       = 1'b1;
        dmem_write_enable = (cls == CLS_STORE);
        if (bus.dmem_ready) begin
          pc_write = (cls == CLS_STORE);
        end else if (timeout) begin
          pc_write = 1'b1;
          mem_err  = 1'b1;
        end
      end
      WB: begin
        reg_write = (cls == CLS_CALL) ? 2'b10 : 2'b01;
        pc_write  = (cls != CLS_CALL);
      end
      default: ;
    endcase
  end

  assign bus.ir_write           = ir_write;
  assign bus.pc_write           = pc_write;
  assign bus.reg_write          = reg_write;
  assign bus.imm_mux_ctrl       = imm_mux_ctrl;
  assign bus.alu_mux_ctrl       = alu_mux_ctrl;
  assign bus.alu_op             = alu_op;
  assign bus.dmem_enable        = dmem_enable;
  assign bus.dmem_write_enable  = dmem_write_enable;
  assign bus.reg_write_mux_ctrl = reg_write_mux_ctrl;
  assign bus.br_op              = br_op;
  assign bus.is_branch          = is_branch;
  assign bus.illegal            = illegal;
  assign bus.mem_err            = mem_err;
  assign bus.state_out          = state_q;

`ifdef KGP_CTRL_PERF_EN
  logic [31:0] cyc_q, cyc_d, ins_q, ins_d;

  always_comb begin
    cyc_d = cyc_q + 32'd1;
    ins_d = ins_q + 32'(pc_write);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ins_q <= ins_d;
    end
  end

  assign bus.cycle_count = cyc_q;
  assign bus.instr_count = ins_q;
`endif

endmodule

// File: tb/tb_kgp_multicycle_ctrl.sv
// Self-checking bench for kgp_multicycle_ctrl: directed instruction table, halt/reset sequences,
// and random instruction streams compared cycle by cycle against an instruction-level trace model.
module tb_kgp_multicycle_ctrl;
  localparam int OPC_W = 6, FUNC_W = 6, MEM_TIMEOUT = 15, TO_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  kgp_multicycle_ctrl_if #(.OPC_W(OPC_W), .FUNC_W(FUNC_W)) bus ();

  kgp_multicycle_ctrl #(
    .OPC_W(OPC_W), .FUNC_W(FUNC_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic       ir, pc;
    logic [1:0] rw;
    logic       imm, amux;
    logic [3:0] aop;
    logic       den, dwe;
    logic [1:0] wbm;
    logic [4:0] br;
    logic       isb, ill, merr;
    logic [2:0] st;
  } out_t;

  typedef struct {
    logic halt;
    logic ready;
    out_t exp;
  } cyc_t;

  typedef struct {
    string      name;
    logic [5:0] opc;
    logic [5:0] f;
    int         waits;   // not-ready MEM cycles before ready; -1 = never ready
    int         cycles;
    int         ill;
    int         merr;
  } dir_t;

  typedef enum {K_R, K_I, K_LD, K_ST, K_BR, K_CALL, K_ILL} kind_e;

  int   errors = 0;
  int   checks = 0;
  cyc_t trace[$];
  dir_t dirs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.ir   = bus.ir_write;
    o.pc   = bus.pc_write;
    o.rw   = bus.reg_write;
    o.imm  = bus.imm_mux_ctrl;
    o.amux = bus.alu_mux_ctrl;
    o.aop  = bus.alu_op;
    o.den  = bus.dmem_enable;
    o.dwe  = bus.dmem_write_enable;
    o.wbm  = bus.reg_write_mux_ctrl;
    o.br   = bus.br_op;
    o.isb  = bus.is_branch;
    o.ill  = bus.illegal;
    o.merr = bus.mem_err;
    o.st   = bus.state_out;
    return o;
  endfunction

  function automatic kind_e kind_of(input logic [5:0] opc, input logic [5:0] f);
    case (opc)
      6'd0:    return K_R;
      6'd1:    return K_I;
      6'd2:    return K_LD;
      6'd3:    return K_ST;
      6'd4:    return (f[4:0] == 5'h02) ? K_CALL : K_BR;
      default: return K_ILL;
    endcase
  endfunction

  function automatic out_t dec(input kind_e k, input logic [5:0] f);
    out_t o = '0;
    case (k)
      K_R:        begin o.aop = f[3:0]; o.wbm = 2'b10; end
      K_I:        begin o.aop = f[3:0]; o.wbm = 2'b10; o.amux = 1'b1; end
      K_LD, K_ST: begin o.amux = 1'b1; o.imm = 1'b1; o.wbm = 2'b01; end
      K_BR, K_CALL: o.br = f[4:0];
      default: ;
    endcase
    return o;
  endfunction

  // Expected per-cycle trace of one instruction, phase by phase.
  task automatic build(input logic [5:0] opc, input logic [5:0] f, input int waits,
                       input int stalls, input bit noise);
    kind_e k = kind_of(opc, f);
    out_t  d = dec(k, f);
    cyc_t  c;
    bit    wb;
    trace.delete();
    for (int i = 0; i < stalls; i++) begin
      c.halt = 1'b1; c.ready = noise ? 1'($urandom) : 1'b0; c.exp = '0;
      trace.push_back(c);
    end
    c.halt = 1'b0; c.ready = noise ? 1'($urandom) : 1'b0; c.exp = '0; c.exp.ir = 1'b1;
    trace.push_back(c);
    c.halt = noise ? 1'($urandom) : 1'b0; c.ready = noise ? 1'($urandom) : 1'b0;
    c.exp = d; c.exp.st = 3'd1;
    trace.push_back(c);
    c.halt = noise ? 1'($urandom) : 1'b0; c.ready = noise ? 1'($urandom) : 1'b0;
    c.exp = d; c.exp.st = 3'd2;
    if (k == K_BR || k == K_CALL) begin c.exp.pc = 1'b1; c.exp.isb = 1'b1; end
    if (k == K_ILL) begin c.exp.pc = 1'b1; c.exp.ill = 1'b1; end
    trace.push_back(c);
    wb = (k == K_R || k == K_I || k == K_CALL);
    if (k == K_LD || k == K_ST) begin
      for (int n = 0; n <= MEM_TIMEOUT; n++) begin
        bit rdy = (waits >= 0) && (n == waits);
        bit to  = (n == MEM_TIMEOUT);
        c.halt = noise ? 1'($urandom) : 1'b0; c.ready = rdy;
        c.exp = d; c.exp.st = 3'd3; c.exp.den = 1'b1; c.exp.dwe = (k == K_ST);
        if (rdy) c.exp.pc = (k == K_ST);
        else if (to) begin c.exp.pc = 1'b1; c.exp.merr = 1'b1; end
        trace.push_back(c);
        if (rdy && k == K_LD) wb = 1'b1;
        if (rdy || to) break;
      end
    end
    if (wb) begin
      c.halt = noise ? 1'($urandom) : 1'b0; c.ready = noise ? 1'($urandom) : 1'b0;
      c.exp = d; c.exp.st = 3'd4;
      c.exp.rw = (k == K_CALL) ? 2'b10 : 2'b01;
      c.exp.pc = (k != K_CALL);
      trace.push_back(c);
    end
  endtask

  // Drives the trace one cycle per record (from a negedge), compares, then checks totals.
  task automatic apply(input string name, input logic [5:0] opc, input logic [5:0] f,
                       input int cyc, input int ill, input int merr);
    int   busy = 0, npc = 0, nill = 0, nmerr = 0;
    out_t a;
    bus.opcode = opc;
    bus.func   = f;
    foreach (trace[i]) begin
      bus.halt       = trace[i].halt;
      bus.dmem_ready = trace[i].ready;
      #2;
      a = sample();
      check($sformatf("%s[%0d]", name, i), 32'(a), 32'(trace[i].exp));
      if (a.st != 3'd0) busy++;
      npc   += int'(a.pc);
      nill  += int'(a.ill);
      nmerr += int'(a.merr);
      @(negedge clk);
    end
    check({name, "_cycles"}, 32'(busy + 1), 32'(cyc));
    check({name, "_pc_writes"}, 32'(npc), 32'd1);
    check({name, "_illegal"}, 32'(nill), 32'(ill));
    check({name, "_mem_err"}, 32'(nmerr), 32'(merr));
  endtask

  initial begin
    out_t fe;
    bus.opcode = '0; bus.func = '0; bus.halt = 1'b0; bus.dmem_ready = 1'b0;

    dirs[0]  = '{"r_type",    6'h00, 6'h03,  0,  4, 0, 0};
    dirs[1]  = '{"i_addi",    6'h01, 6'h00,  0,  4, 0, 0};
    dirs[2]  = '{"load_w3",   6'h02, 6'h00,  3,  8, 0, 0};
    dirs[3]  = '{"store_to",  6'h03, 6'h00, -1, 19, 0, 1};
    dirs[4]  = '{"branch",    6'h04, 6'h01,  0,  3, 0, 0};
    dirs[5]  = '{"call",      6'h04, 6'h02,  0,  4, 0, 0};
    dirs[6]  = '{"illegal",   6'h3F, 6'h00,  0,  3, 1, 0};
    dirs[7]  = '{"store_rdy", 6'h03, 6'h15,  0,  4, 0, 0};
    dirs[8]  = '{"load_race", 6'h02, 6'h00, 15, 20, 0, 0};
    dirs[9]  = '{"call_f5",   6'h04, 6'h22,  0,  4, 0, 0};
    dirs[10] = '{"r_f1f",     6'h00, 6'h1F,  0,  4, 0, 0};

    repeat (2) @(negedge clk);
    #2;
    check("reset_state", 32'(sample()), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (dirs[i]) begin
      build(dirs[i].opc, dirs[i].f, dirs[i].waits, 0, 1'b0);
      apply(dirs[i].name, dirs[i].opc, dirs[i].f, dirs[i].cycles, dirs[i].ill, dirs[i].merr);
    end

    build(6'h00, 6'h05, 0, 3, 1'b0);
    apply("halt_hold", 6'h00, 6'h05, 4, 0, 0);

    // Store that never completes, hit with reset in its third MEM cycle.
    bus.opcode = 6'h03; bus.func = '0;
    build(6'h03, 6'h00, -1, 0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      bus.halt = trace[i].halt; bus.dmem_ready = trace[i].ready;
      #2;
      check($sformatf("pre_rst[%0d]", i), 32'(sample()), 32'(trace[i].exp));
      if (i < 5) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    check("rst_async", 32'(sample()), 32'd0);
    @(negedge clk);
    bus.dmem_ready = 1'b1;
    #2;
    check("rst_hold", 32'(sample()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.dmem_ready = 1'b0;

    build(6'h01, 6'h09, 0, 0, 1'b0);
    apply("after_rst", 6'h01, 6'h09, 4, 0, 0);

    for (int n = 0; n < 150; n++) begin
      logic [5:0] opc, f;
      int r, w, waits, cyc, ill, merr;
      r     = $urandom_range(0, 5);
      opc   = (r < 5) ? 6'(r) : 6'($urandom_range(5, 63));
      f     = 6'($urandom);
      w     = $urandom_range(0, 7);
      waits = (w == 6) ? -1 : (w == 7) ? 15 : w;
      build(opc, f, waits, $urandom_range(0, 2), 1'b1);
      cyc = 1; ill = 0; merr = 0;
      foreach (trace[i]) begin
        if (trace[i].exp.st != 3'd0) cyc++;
        ill  += int'(trace[i].exp.ill);
        merr += int'(trace[i].exp.merr);
      end
      apply($sformatf("rand%0d_op%0h", n, opc), opc, f, cyc, ill, merr);
    end

    bus.halt = 1'b0;
    #2;
    fe = '0;
    fe.ir = 1'b1;
    check("final_fetch", 32'(sample()), 32'(fe));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
